// File: rtl/mux_sel_rr_arb.sv
// Round-robin arbiter driving the 2-bit select of a 4:1 data mux.
// A grant is held for up to MAX_BEATS accepted beats while its channel keeps
// requesting. After that the grant rotates, and the current channel becomes
// the lowest priority. sel_out doubles as the round-robin pointer.
module mux_sel_rr_arb #(
    parameter int MAX_BEATS = 4
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [3:0] req_in,
    input  logic       ready_in,
    output logic [1:0] sel_out,
    output logic [3:0] grant_out,
    output logic       valid_out,
    output logic       last_out
);

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BEATS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] sel_nxt;
    logic [3:0] grant_nxt;
    logic       valid_nxt;
    logic [3:0] beat_cnt, beat_nxt;

    logic [1:0] winner;
    logic [1:0] cand;
    logic       any_req;

    assign any_req = |req_in;

    // Search sel_out+1, +2, +3, +0. The loop runs from the farthest candidate
    // to the nearest, so the nearest requester is written last and wins.
    always_comb begin
        winner = sel_out;
        cand   = sel_out;
        for (int k = 4; k >= 1; k--) begin
            cand = sel_out + 2'(k);
            if (req_in[cand]) winner = cand;
        end
    end

    // Next-state and next-register values. Defaults hold everything, which
    // covers both IDLE with no request and backpressure.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_out;
        grant_nxt = grant_out;
        valid_nxt = valid_out;
        beat_nxt  = beat_cnt;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = GRANT;
                    sel_nxt   = winner;
                    grant_nxt = 4'b0001 << winner;
                    valid_nxt = 1'b1;
                    beat_nxt  = 4'd0;
                end
            end
            GRANT: begin
                if (ready_in && req_in[sel_out] && (beat_cnt < LAST_BEAT)) begin
                    beat_nxt = beat_cnt + 4'd1;
                end else if (ready_in || !req_in[sel_out]) begin
                    // Accepted last beat, or the owner withdrew: re-arbitrate.
                    if (any_req) begin
                        sel_nxt   = winner;
                        grant_nxt = 4'b0001 << winner;
                        valid_nxt = 1'b1;
                        beat_nxt  = 4'd0;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = 4'b0000;
                        valid_nxt = 1'b0;
                        beat_nxt  = 4'd0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers. Reset leaves the pointer at 3 so that
    // channel 0 is preferred first.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            sel_out   <= 2'b11;
            grant_out <= 4'b0000;
            valid_out <= 1'b0;
            beat_cnt  <= 4'd0;
        end else begin
            state     <= state_nxt;
            sel_out   <= sel_nxt;
            grant_out <= grant_nxt;
            valid_out <= valid_nxt;
            beat_cnt  <= beat_nxt;
        end
    end

    // Final-beat flag. It depends only on registers.
    assign last_out = valid_out && (beat_cnt == LAST_BEAT);

endmodule
